// File: rtl/uart_pkt_rx.sv
// Packet receiver on a UART RX FIFO.
// Frame: SOF, LEN, LEN payload bytes, CHK (XOR of LEN and the payload). The payload is replayed as a valid/ready stream.
module uart_pkt_rx #(
    parameter int unsigned         DBITS   = 8,
    parameter int unsigned         MAX_LEN = 16,
    parameter logic [DBITS-1:0]    SOF     = 'hA5
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_rx_empty,
    input  logic [DBITS-1:0]               i_rd_data,
    input  logic [2:0]                     i_err,
    output logic                           o_rd_uart,
    output logic [DBITS-1:0]               o_pkt_data,
    output logic                           o_pkt_valid,
    input  logic                           i_pkt_ready,
    output logic                           o_pkt_last,
    output logic [$clog2(MAX_LEN+1)-1:0]   o_pkt_len,
    output logic                           o_pkt_done,
    output logic                           o_chk_err,
    output logic                           o_len_err,
    output logic                           o_frm_err
);

    localparam int unsigned      LW      = $clog2(MAX_LEN + 1);
    localparam int unsigned      IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [DBITS-1:0] LEN_MAX = DBITS'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_OUT
    } state_t;

    state_t           state;
    logic [LW-1:0]    len;
    logic [LW-1:0]    cnt;
    logic [LW-1:0]    idx;
    logic [DBITS-1:0] xacc;
    logic [DBITS-1:0] mem [MAX_LEN];

    logic             pop;
    logic             bad_byte;
    logic [LW-1:0]    cnt_nx;
    logic [LW-1:0]    idx_nx;

    // Pop whenever parsing; OUT never pops so the UART FIFO absorbs backpressure.
    always_comb begin
        pop      = i_rst_n && (state != ST_OUT) && !i_rx_empty;
        bad_byte = pop && (i_err != 3'b000);
        cnt_nx   = cnt + LW'(1);
        idx_nx   = idx + LW'(1);
    end

    assign o_rd_uart = pop;

    // Payload buffer; contents are don't-care after reset.
    always_ff @(posedge i_clk) begin
        if (pop && !bad_byte && state == ST_PAYLOAD)
            mem[IW'(cnt)] <= i_rd_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            len         <= '0;
            cnt         <= '0;
            idx         <= '0;
            xacc        <= '0;
            o_pkt_data  <= '0;
            o_pkt_valid <= 1'b0;
            o_pkt_last  <= 1'b0;
            o_pkt_len   <= '0;
            o_pkt_done  <= 1'b0;
            o_chk_err   <= 1'b0;
            o_len_err   <= 1'b0;
            o_frm_err   <= 1'b0;
        end else begin
            o_pkt_done <= 1'b0;
            o_chk_err  <= 1'b0;
            o_len_err  <= 1'b0;
            o_frm_err  <= 1'b0;

            if (bad_byte) begin
                // A flagged byte aborts any frame in progress.
                o_frm_err <= 1'b1;
                state     <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (pop && i_rd_data == SOF)
                            state <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (pop) begin
                            xacc <= i_rd_data;
                            cnt  <= '0;
                            len  <= LW'(i_rd_data);
                            if (i_rd_data > LEN_MAX) begin
                                o_len_err <= 1'b1;
                                state     <= ST_IDLE;
                            end else if (i_rd_data == '0) begin
                                state <= ST_CHK;
                            end else begin
                                state <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (pop) begin
                            xacc <= xacc ^ i_rd_data;
                            cnt  <= cnt_nx;
                            if (cnt_nx == len)
                                state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (pop) begin
                            if (i_rd_data != xacc) begin
                                o_chk_err <= 1'b1;
                                state     <= ST_IDLE;
                            end else if (len == '0) begin
                                o_pkt_len  <= '0;
                                o_pkt_done <= 1'b1;
                                state      <= ST_IDLE;
                            end else begin
                                o_pkt_len   <= len;
                                idx         <= '0;
                                o_pkt_valid <= 1'b1;
                                o_pkt_data  <= mem[0];
                                o_pkt_last  <= (len == LW'(1));
                                state       <= ST_OUT;
                            end
                        end
                    end
                    ST_OUT: begin
                        if (o_pkt_valid && i_pkt_ready) begin
                            if (o_pkt_last) begin
                                o_pkt_valid <= 1'b0;
                                o_pkt_last  <= 1'b0;
                                o_pkt_done  <= 1'b1;
                                state       <= ST_IDLE;
                            end else begin
                                idx        <= idx_nx;
                                o_pkt_data <= mem[IW'(idx_nx)];
                                o_pkt_last <= (idx_nx + LW'(1) == len);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Directed bench for uart_pkt_rx: an array-backed FIFO model feeds frames and a monitor logs beats and pulses.
module tb_uart_pkt_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_empty;
    logic [7:0] rd_data;
    logic [2:0] err;
    logic       rd_uart;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready = 1'b1;
    logic       pkt_last;
    logic [4:0] pkt_len;
    logic       pkt_done, chk_err, len_err, frm_err;

    uart_pkt_rx #(.DBITS(8), .MAX_LEN(16), .SOF(8'hA5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_empty(rx_empty), .i_rd_data(rd_data),
        .i_err(err), .o_rd_uart(rd_uart), .o_pkt_data(pkt_data), .o_pkt_valid(pkt_valid),
        .i_pkt_ready(pkt_ready), .o_pkt_last(pkt_last), .o_pkt_len(pkt_len),
        .o_pkt_done(pkt_done), .o_chk_err(chk_err), .o_len_err(len_err), .o_frm_err(frm_err)
    );

    always #5 clk = ~clk;

    // FIFO model: bench writes at the negedge, the pop pointer advances on the posedge.
    logic [7:0] fmem [256];
    logic [2:0] ferr [256];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;

    assign rx_empty = (rd_ptr == wr_ptr);
    assign rd_data  = rx_empty ? 8'h00 : fmem[rd_ptr[7:0]];
    assign err      = rx_empty ? 3'b000 : ferr[rd_ptr[7:0]];

    always @(posedge clk) if (rd_uart && !rx_empty) rd_ptr <= rd_ptr + 1;

    // Monitor: transferred beats and pulse counts.
    logic [7:0] bq[$];
    logic       lq[$];
    int n_done = 0, n_chk = 0, n_len = 0, n_frm = 0;

    always @(posedge clk) begin
        if (pkt_valid && pkt_ready) begin
            bq.push_back(pkt_data);
            lq.push_back(pkt_last);
        end
        if (pkt_done) n_done <= n_done + 1;
        if (chk_err)  n_chk  <= n_chk + 1;
        if (len_err)  n_len  <= n_len + 1;
        if (frm_err)  n_frm  <= n_frm + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic [2:0] e = 3'b000);
        fmem[wr_ptr[7:0]] = b;
        ferr[wr_ptr[7:0]] = e;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int b0, d0, c0, l0, f0, k;

    initial begin
        // Reset: a pending byte must not be popped while reset is low.
        @(negedge clk);
        push(8'h00);
        cycles(2);
        check("rst_rd_uart", 32'(rd_uart), 0);
        check("rst_valid",   32'(pkt_valid), 0);
        check("rst_data",    32'(pkt_data), 0);
        check("rst_len",     32'(pkt_len), 0);
        check("rst_pulses",  32'({pkt_done, chk_err, len_err, frm_err, pkt_last}), 0);
        rst_n = 1'b1;
        cycles(3);

        // Good frame: XOR(03,11,22,33) = 03.
        b0 = bq.size(); d0 = n_done;
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h03);
        cycles(30);
        check("good_nbeats", 32'(bq.size() - b0), 3);
        if (bq.size() - b0 == 3) begin
            check("good_b0", 32'(bq[b0]),   32'h11);
            check("good_b1", 32'(bq[b0+1]), 32'h22);
            check("good_b2", 32'(bq[b0+2]), 32'h33);
            check("good_last", 32'({lq[b0], lq[b0+1], lq[b0+2]}), 32'b001);
        end
        check("good_len",  32'(pkt_len), 3);
        check("good_done", 32'(n_done - d0), 1);

        // Bad checksum (02^10^20=32, not FF), then a good frame 01 55 54.
        b0 = bq.size(); d0 = n_done; c0 = n_chk;
        push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'hFF);
        cycles(20);
        check("chk_pulse",  32'(n_chk - c0), 1);
        check("chk_nbeats", 32'(bq.size() - b0), 0);
        push(8'hA5); push(8'h01); push(8'h55); push(8'h54);
        cycles(20);
        check("chk_next_nbeats", 32'(bq.size() - b0), 1);
        if (bq.size() > b0) check("chk_next_b0", 32'(bq[b0]), 32'h55);
        check("chk_next_done", 32'(n_done - d0), 1);
        check("chk_next_len",  32'(pkt_len), 1);

        // Hunt for SOF, zero-length frame.
        b0 = bq.size(); d0 = n_done;
        push(8'h00); push(8'h5A); push(8'hA5); push(8'h00); push(8'h00);
        cycles(20);
        check("zero_done",   32'(n_done - d0), 1);
        check("zero_len",    32'(pkt_len), 0);
        check("zero_nbeats", 32'(bq.size() - b0), 0);

        // Length error (0x11 > 16), then A5 01 7E 7F.
        b0 = bq.size(); l0 = n_len;
        push(8'hA5); push(8'h11);
        cycles(10);
        check("len_err_pulse", 32'(n_len - l0), 1);
        push(8'hA5); push(8'h01); push(8'h7E); push(8'h7F);
        cycles(20);
        check("len_next_nbeats", 32'(bq.size() - b0), 1);
        if (bq.size() > b0) check("len_next_b0", 32'(bq[b0]), 32'h7E);

        // Backpressure: frame 02 C1 C2 (chk 01), a second frame queued behind it.
        b0 = bq.size(); d0 = n_done;
        pkt_ready = 1'b0;
        push(8'hA5); push(8'h02); push(8'hC1); push(8'hC2); push(8'h01);
        push(8'hA5); push(8'h01); push(8'h99); push(8'h98);
        k = 0;
        while (!pkt_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("bp_valid_rise", 32'(pkt_valid), 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_data_hold", 32'(pkt_data), 32'hC1);
            check("bp_no_pop",    32'(rd_uart), 0);
            @(negedge clk);
        end
        check("bp_fifo_level", wr_ptr - rd_ptr, 4);
        pkt_ready = 1'b1;
        cycles(30);
        check("bp_nbeats", 32'(bq.size() - b0), 3);
        if (bq.size() - b0 == 3) begin
            check("bp_b0", 32'(bq[b0]),   32'hC1);
            check("bp_b1", 32'(bq[b0+1]), 32'hC2);
            check("bp_b2", 32'(bq[b0+2]), 32'h99);
        end
        check("bp_done", 32'(n_done - d0), 2);

        // Framing error on the second payload byte.
        b0 = bq.size(); f0 = n_frm;
        push(8'hA5); push(8'h03); push(8'h01); push(8'h02, 3'b001);
        cycles(15);
        check("frm_pulse",  32'(n_frm - f0), 1);
        check("frm_nbeats", 32'(bq.size() - b0), 0);

        // Reset in the middle of PAYLOAD, then a clean frame 02 12 34 (chk 24).
        push(8'hA5); push(8'h04); push(8'h0A); push(8'h0B);
        cycles(8);
        rst_n = 1'b0;
        push(8'h5A);
        cycles(2);
        check("midrst_rd_uart", 32'(rd_uart), 0);
        check("midrst_outs", 32'({pkt_valid, pkt_last, pkt_data, pkt_len}), 0);
        rst_n = 1'b1;
        cycles(3);
        b0 = bq.size(); d0 = n_done;
        push(8'hA5); push(8'h02); push(8'h12); push(8'h34); push(8'h24);
        cycles(20);
        check("post_rst_nbeats", 32'(bq.size() - b0), 2);
        if (bq.size() - b0 == 2) begin
            check("post_rst_b0", 32'(bq[b0]),   32'h12);
            check("post_rst_b1", 32'(bq[b0+1]), 32'h34);
        end
        check("post_rst_done", 32'(n_done - d0), 1);
        check("post_rst_len",  32'(pkt_len), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_pkt_rx.md
UART_PKT_RX -- requirements
Module: uart_pkt_rx

Interface
REQ-001 SHALL have parameter DBITS, default 8, width of the UART data byte.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload length in bytes.
REQ-003 SHALL have parameter SOF, default 8'hA5, start-of-frame byte.
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_rx_empty  input  1  UART RX FIFO empty.
REQ-007 SHALL have port i_rd_data  input  DBITS  RX FIFO head byte; first-word-fall-through, valid whenever i_rx_empty=0.
REQ-008 SHALL have port i_err  input  3  UART error flags qualifying i_rd_data.
REQ-009 SHALL have port o_rd_uart  output  1  RX FIFO pop; one byte is consumed per cycle high.
REQ-010 SHALL have port o_pkt_data  output  DBITS  payload byte out.
REQ-011 SHALL have port o_pkt_valid  output  1  o_pkt_data valid.
REQ-012 SHALL have port i_pkt_ready  input  1  sink accepts the beat.
REQ-013 SHALL have port o_pkt_last  output  1  marks the final payload beat.
REQ-014 SHALL have port o_pkt_len  output  $clog2(MAX_LEN+1)  length of the packet being output; held until the next packet.
REQ-015 SHALL have port o_pkt_done  output  1  one-cycle pulse when a good packet completes.
REQ-016 SHALL have port o_chk_err  output  1  one-cycle pulse on checksum mismatch.
REQ-017 SHALL have port o_len_err  output  1  one-cycle pulse when LEN exceeds MAX_LEN.
REQ-018 SHALL have port o_frm_err  output  1  one-cycle pulse when a popped byte has i_err != 0.

Function
REQ-019 SHALL implement the frame format: SOF, LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
REQ-020 SHALL implement states IDLE, LEN, PAYLOAD, CHK and OUT.
REQ-021 SHALL drive o_rd_uart combinationally as (state in IDLE/LEN/PAYLOAD/CHK) && !i_rx_empty, and SHALL sample i_rd_data and i_err in the same cycle.
REQ-022 SHALL never assert o_rd_uart in OUT, so that backpressure fills the RX FIFO.
REQ-023 SHALL, in IDLE, discard popped bytes other than SOF; a popped SOF SHALL move the block to LEN.
REQ-024 SHALL, in LEN, pop one byte and then: LEN > MAX_LEN -> pulse o_len_err and go to IDLE; LEN = 0 -> go to CHK; otherwise go to PAYLOAD.
REQ-025 SHALL, in PAYLOAD, store each byte in an internal MAX_LEN x DBITS buffer at an incrementing index and update a running XOR; after byte LEN it SHALL go to CHK.
REQ-026 SHALL, in CHK, pop one byte and then: on mismatch, pulse o_chk_err and go to IDLE; on match with LEN > 0, latch o_pkt_len and go to OUT; on match with LEN = 0, set o_pkt_len = 0, pulse o_pkt_done the next cycle, emit no beats and go to IDLE.
REQ-027 SHALL, for any popped byte with i_err != 0 in any state, discard the byte, pulse o_frm_err and go to IDLE, overriding REQ-023..REQ-026.
REQ-028 SHALL, in OUT, assert o_pkt_valid from the cycle after the CHK pop, with o_pkt_data = buffer[idx] and o_pkt_last = (idx == LEN-1).
REQ-029 SHALL treat a beat as transferred when o_pkt_valid && i_pkt_ready; data SHALL hold stable while i_pkt_ready = 0.
REQ-030 SHALL, on transfer of the last beat, drop o_pkt_valid next cycle, pulse o_pkt_done in that cycle, and return to IDLE.
REQ-031 SHALL allow back-to-back pops, one byte per cycle, with no idle cycle between frames.
REQ-032 SHALL make all counters and indices $clog2(MAX_LEN+1) bits wide; the XOR SHALL be DBITS wide.

Reset
REQ-033 SHALL, on i_rst_n = 0 at any time including mid-frame, asynchronously enter IDLE and clear all counters and the XOR.
REQ-034 SHALL, while i_rst_n = 0, drive o_rd_uart = 0, o_pkt_valid = 0, o_pkt_last = 0, o_pkt_data = 0, o_pkt_len = 0 and all pulse outputs = 0.
REQ-035 SHALL leave the buffer contents uncleared on reset; they are don't-care.

Verification
REQ-036 SHALL verify good frame: A5 03 11 22 33 03 -> beats 11, 22, 33 with last on 33, o_pkt_len = 3, one o_pkt_done pulse.
REQ-037 SHALL verify bad checksum: A5 02 10 20 FF -> one o_chk_err pulse, no beats, next frame accepted.
REQ-038 SHALL verify hunt and zero length: 00 5A A5 00 00 -> 00 and 5A discarded, o_pkt_done pulse, o_pkt_len = 0, no beats.
REQ-039 SHALL verify length error: A5 11 (17 > MAX_LEN = 16) -> o_len_err pulse, return to IDLE, subsequent A5 01 7E 7F yields beat 7E.
REQ-040 SHALL verify backpressure: i_pkt_ready held low 5 cycles during OUT -> o_pkt_data stable, o_rd_uart = 0 throughout.
REQ-041 SHALL verify errors and reset: i_err = 3'b001 on the 2nd payload byte -> o_frm_err pulse; reset asserted mid-PAYLOAD -> outputs zero and a clean frame received after release.
